fetch_stage: RTL and testbench

Pipelined instruction-fetch front end for the DLX-style processor. It owns the IAR, issues word requests to a latency-tolerant instruction memory, buffers returned instructions with their PCs in a small FIFO, and hands them to decode/Control over a valid/ready handshake. Branch/jump resolution downstream redirects it through `redirect_valid`/`redirect_pc`, which squashes all buffered and in-flight fetches.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, the decode no-op word and the fetch FSM encoding.
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // Shown on id_instr whenever the head is empty; all-zero decodes as a no-op.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count. Read data is taken
// straight from the storage array, so a pushed word shows up on pop_data
// no earlier than the edge after the push. DEPTH must be a power of two,
// which lets the pointers wrap on their own.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Flush wins over both ports; a push into a full FIFO is only taken when
  // the same cycle frees a slot.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is read from a slot that was not written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the IAR, issues word requests with a
// credit limit of DEPTH (buffered + in flight), tracks in-flight PCs in
// order, buffers returned words and presents them to decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | just out of reset; no requests, outputs quiet
// ST_FETCH | issuing requests whenever a credit is free and no redirect
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus8
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  fetch_state_e               state_q;
  logic [ADDR_W-1:0]          iar_q;
  logic [CNT_W-1:0]           disc_q;
  logic [CNT_W-1:0]           infl;
  logic [CNT_W-1:0]           out_cnt;
  logic [CNT_W:0]             credit_used;
  logic                       pcq_empty;
  logic                       out_empty;
  logic [ADDR_W-1:0]          resp_pc;
  logic [INSTR_W+ADDR_W-1:0]  head;
  logic                       req_fire;
  logic                       resp_fire;
  logic                       out_push;
  logic                       id_fire;
  logic                       unused_redirect_lsb;

  // Target is always word aligned; the low bits are ignored on purpose.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Every request holds a slot from issue until decode consumes it, so the
  // output FIFO can never overflow. Squashed requests keep their credit
  // until their response comes back and is dropped.
  assign credit_used    = {1'b0, out_cnt} + {1'b0, infl};
  assign imem_req_valid = (state_q == ST_FETCH) && !redirect_valid &&
                          (credit_used < CREDIT_MAX);
  assign imem_req_addr  = iar_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid && !pcq_empty;
  assign out_push       = resp_fire && !redirect_valid && (disc_q == '0);
  assign id_fire        = id_valid && id_ready && !redirect_valid;

  assign id_valid    = !out_empty;
  assign id_instr    = id_valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : NOP_INSTR;
  assign id_pc       = id_valid ? head[ADDR_W-1:0] : '0;
  assign id_pc_plus8 = id_valid ? head[ADDR_W-1:0] + 32'd8 : '0;

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (iar_q),
    .pop       (resp_fire),
    .pop_data  (resp_pc),
    .count     (infl),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (out_push),
    .push_data ({imem_resp_data, resp_pc}),
    .pop       (id_fire),
    .pop_data  (head),
    .count     (out_cnt),
    .empty     (out_empty)
  );

  // FSM: one idle cycle after reset, then fetch until the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= ST_FETCH;
  end

  // IAR: redirect overrides the post-increment of an accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              iar_q <= RESET_PC;
    else if (redirect_valid) iar_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (req_fire)       iar_q <= iar_q + 32'd4;
  end

  // Discard count: on redirect everything still outstanding after this
  // cycle's response must be dropped; the response arriving in the
  // redirect cycle itself is already dropped and does not count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          disc_q <= '0;
    else if (redirect_valid)             disc_q <= infl - CNT_W'(resp_fire);
    else if (resp_fire && disc_q != '0)  disc_q <= disc_q - CNT_W'(1);
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus8     (id_pc_plus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          squashed;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       pend[$];      // requests held by the memory model
  exp_t        expq[$];      // scoreboard: expected decode stream
  logic [31:0] seen_pc[$];
  logic [31:0] seen_p8[$];
  int          seen_cyc[$];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          m_fifo   = 0;
  bit          m_fetch  = 0;
  logic [31:0] m_iar    = RESET_PC;
  int          n_req    = 0;
  int          n_fire   = 0;
  int          s0;
  int          mark;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    expq.delete();
    m_fifo  = 0;
    m_iar   = RESET_PC;
    m_fetch = 0;
  endtask

  // One clock cycle: drive inputs just after the rising edge, compare at the
  // falling edge against the model, update the model, advance to next edge.
  task automatic cycle(input bit rdr, input logic [31:0] rpc);
    bit    exp_req;
    bit    exp_idv;
    bit    fire;
    mreq_t h;
    exp_t  e;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    @(negedge clk);
    exp_req = m_fetch && !rdr && (m_fifo + pend.size() < DEPTH);
    exp_idv = (m_fifo > 0);
    check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
    check("imem_req_addr", imem_req_addr, m_iar);
    check("id_valid", 32'(id_valid), 32'(exp_idv));
    fire = exp_idv && id_ready && !rdr;
    if (fire && expq.size() > 0) begin
      e = expq.pop_front();
      check("id_pc", id_pc, e.pc);
      check("id_instr", id_instr, e.instr);
      check("id_pc_plus8", id_pc_plus8, e.pc + 32'd8);
      seen_pc.push_back(id_pc);
      seen_p8.push_back(id_pc_plus8);
      seen_cyc.push_back(cyc);
      m_fifo--;
      n_fire++;
    end
    if (imem_resp_valid) begin
      h = pend.pop_front();
      if (!h.squashed && !rdr) m_fifo++;
    end
    if (exp_req && imem_req_ready) begin
      pend.push_back('{m_iar, cyc + lat, 1'b0});
      expq.push_back('{m_iar, mem_word(m_iar)});
      m_iar += 32'd4;
      n_req++;
    end
    if (rdr) begin
      m_fifo = 0;
      expq.delete();
      foreach (pend[i]) pend[i].squashed = 1'b1;
      m_iar = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) m_fetch = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b1;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus8", id_pc_plus8, 32'd0);

    // Streaming with 1-cycle memory and decode always ready.
    reset = 1'b1;
    run(25);
    check("stream_n_fires", 32'(seen_pc.size() >= 2), 32'd1);
    check("stream_pc0", seen_pc[0], 32'h0);
    check("stream_pc1", seen_pc[1], 32'h4);
    check("stream_p8_0", seen_p8[0], 32'h8);
    check("stream_p8_1", seen_p8[1], 32'hC);
    check("stream_back_to_back", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
    mark = n_fire;
    run(10);
    check("throughput", 32'(n_fire - mark), 32'd10);

    // Memory not ready: address must hold.
    imem_req_ready = 1'b0;
    run(3);
    imem_req_ready = 1'b1;

    // Decode stalled: exactly DEPTH requests, then fetch holds.
    id_ready = 1'b0;
    mark = n_req;
    cycle(1'b1, 32'h0000_0200);
    run(10);
    check("stall_requests", 32'(n_req - mark), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    s0 = seen_pc.size();
    run(8);
    check("stall_release_n", 32'(seen_pc.size() >= s0 + 4), 32'd1);
    check("stall_pc0", seen_pc[s0],     32'h200);
    check("stall_pc1", seen_pc[s0 + 1], 32'h204);
    check("stall_pc2", seen_pc[s0 + 2], 32'h208);
    check("stall_pc3", seen_pc[s0 + 3], 32'h20C);
    check("stall_resume", 32'(n_req - mark > 4), 32'd1);

    // 3-cycle memory, redirect with two requests in flight.
    lat = 3;
    run(10);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(1'b0, 32'h0);
    check("lat3_inflight", 32'(pend.size()), 32'd2);
    imem_req_ready = 1'b1;
    s0 = seen_pc.size();
    cycle(1'b1, 32'h0000_0103);
    run(12);
    check("lat3_redirect_n", 32'(seen_pc.size() > s0), 32'd1);
    check("lat3_redirect_pc", seen_pc[s0], 32'h100);

    // Redirect in the same cycle as a response.
    lat = 2;
    run(6);
    for (int i = 0; i < 20 && !(pend.size() >= 2 && pend[0].due <= cyc); i++)
      cycle(1'b0, 32'h0);
    check("resp_redirect_setup", 32'(pend.size() >= 2 && pend[0].due <= cyc), 32'd1);
    s0 = seen_pc.size();
    cycle(1'b1, 32'h0000_0300);
    run(12);
    check("resp_redirect_n", 32'(seen_pc.size() > s0), 32'd1);
    check("resp_redirect_pc", seen_pc[s0], 32'h300);

    // Address wrap at the top of memory.
    lat = 1;
    s0 = seen_pc.size();
    cycle(1'b1, 32'hFFFF_FFF8);
    run(10);
    check("wrap_n", 32'(seen_pc.size() >= s0 + 3), 32'd1);
    check("wrap_pc0", seen_pc[s0],     32'hFFFF_FFF8);
    check("wrap_pc1", seen_pc[s0 + 1], 32'hFFFF_FFFC);
    check("wrap_pc2", seen_pc[s0 + 2], 32'h0000_0000);
    check("wrap_p8_1", seen_p8[s0 + 1], 32'h0000_0004);

    // Reset in the middle of a stream with the FIFO full.
    id_ready = 1'b0;
    for (int i = 0; i < 20 && m_fifo != DEPTH; i++) cycle(1'b0, 32'h0);
    check("full_before_reset", 32'(id_valid), 32'd1);
    #2;
    reset           = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check("mid_rst_id_valid", 32'(id_valid), 32'd0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_req_addr", imem_req_addr, RESET_PC);
    model_reset();
    @(posedge clk);
    #1;
    run(2);
    reset    = 1'b1;
    id_ready = 1'b1;
    s0 = seen_pc.size();
    run(10);
    check("restart_n", 32'(seen_pc.size() >= s0 + 2), 32'd1);
    check("restart_pc0", seen_pc[s0],     RESET_PC);
    check("restart_pc1", seen_pc[s0 + 1], RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
